// File: rtl/countdown_mode_controller_if.sv
// Button/tick/finished inputs and sequencer outputs shared with the counting datapath.
interface countdown_mode_controller_if;
    logic        btnStart;
    logic        btnMode;
    logic        btnUp;
    logic        secTick;
    logic        finished;
    logic [2:0]  currentState;
    logic [15:0] initialClockValue;
    logic        counterReset;
    logic [1:0]  editDigit;
    logic        alarm;

    // Stimulus side: drives buttons and datapath status, observes the sequencer.
    modport master (
        output btnStart, btnMode, btnUp, secTick, finished,
        input  currentState, initialClockValue, counterReset, editDigit, alarm
    );

    // Sequencer side.
    modport slave (
        input  btnStart, btnMode, btnUp, secTick, finished,
        output currentState, initialClockValue, counterReset, editDigit, alarm
    );
endinterface

// File: rtl/countdown_mode_controller.sv
// Top-level countdown sequencer: owns the shared state ID, edits the BCD preset,
// generates the one-cycle load strobe and runs the timed alarm phase.
module countdown_mode_controller #(
    parameter logic [15:0] DEFAULT_TIME = 16'h0500,
    parameter int unsigned ALARM_TICKS  = 10
) (
    input  logic                          slowclk,
    input  logic                          reset,
    countdown_mode_controller_if.slave    ctl
);

    localparam int unsigned TICK_W = 8;
    localparam int unsigned MASK_W = 2;

    localparam logic [2:0] S_COUNTING = 3'd0;
    localparam logic [2:0] S_SETTING  = 3'd1;
    localparam logic [2:0] S_READY    = 3'd2;
    localparam logic [2:0] S_PAUSED   = 3'd3;
    localparam logic [2:0] S_ALARM    = 3'd4;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(ALARM_TICKS);

    logic [2:0]        r_state;
    logic [15:0]       r_preset;
    logic              r_counter_reset;
    logic [1:0]        r_edit_digit;
    logic              r_alarm;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [MASK_W-1:0] r_mask;
    logic              r_start_prev;
    logic              r_mode_prev;
    logic              r_up_prev;

    logic [2:0]        w_state_nxt;
    logic [15:0]       w_preset_nxt;
    logic              w_counter_reset_nxt;
    logic [1:0]        w_edit_digit_nxt;
    logic              w_alarm_nxt;
    logic [TICK_W-1:0] w_tick_cnt_nxt;
    logic [MASK_W-1:0] w_mask_nxt;

    logic w_mode_p;
    logic w_start_p;
    logic w_up_p;
    logic w_any_p;
    logic w_load;
    logic w_tick_done;

    // BCD digit increment; anything at or above the digit limit wraps to zero.
    function automatic logic [3:0] bcd_inc(input logic [3:0] d, input logic [3:0] lim);
        return (d >= lim) ? 4'd0 : d + 4'd1;
    endfunction

    // Rising-edge press detect with mode > start > up priority.
    always_comb begin
        w_mode_p    = ctl.btnMode & ~r_mode_prev;
        w_start_p   = ctl.btnStart & ~r_start_prev & ~w_mode_p;
        w_up_p      = ctl.btnUp & ~r_up_prev & ~w_mode_p & ~(ctl.btnStart & ~r_start_prev);
        w_any_p     = (ctl.btnMode & ~r_mode_prev) | (ctl.btnStart & ~r_start_prev)
                    | (ctl.btnUp & ~r_up_prev);
        w_tick_done = ctl.secTick && ((r_tick_cnt + TICK_W'(1)) == TICK_LAST);
    end

    // State register and registered outputs/datapath.
    always_ff @(posedge slowclk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_READY;
            r_preset        <= DEFAULT_TIME;
            r_counter_reset <= 1'b1;
            r_edit_digit    <= 2'd3;
            r_alarm         <= 1'b0;
            r_tick_cnt      <= '0;
            r_mask          <= '0;
            r_start_prev    <= 1'b0;
            r_mode_prev     <= 1'b0;
            r_up_prev       <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_preset        <= w_preset_nxt;
            r_counter_reset <= w_counter_reset_nxt;
            r_edit_digit    <= w_edit_digit_nxt;
            r_alarm         <= w_alarm_nxt;
            r_tick_cnt      <= w_tick_cnt_nxt;
            r_mask          <= w_mask_nxt;
            r_start_prev    <= ctl.btnStart;
            r_mode_prev     <= ctl.btnMode;
            r_up_prev       <= ctl.btnUp;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_READY: begin
                if (w_mode_p)
                    w_state_nxt = S_SETTING;
                else if (w_start_p && (r_preset != 16'h0000))
                    w_state_nxt = S_COUNTING;
            end
            S_SETTING: begin
                if (w_mode_p && (r_edit_digit == 2'd0))
                    w_state_nxt = S_READY;
            end
            S_COUNTING: begin
                if (w_mode_p)
                    w_state_nxt = S_READY;
                else if (w_start_p)
                    w_state_nxt = S_PAUSED;
                else if (ctl.finished && (r_mask == '0))
                    w_state_nxt = S_ALARM;
            end
            S_PAUSED: begin
                if (w_mode_p)
                    w_state_nxt = S_READY;
                else if (w_start_p)
                    w_state_nxt = S_COUNTING;
            end
            S_ALARM: begin
                if (w_any_p || w_tick_done)
                    w_state_nxt = S_READY;
            end
            default: w_state_nxt = S_READY;
        endcase
    end

    // Next values of the registered outputs, preset, alarm counter and finished mask.
    always_comb begin
        w_load              = (r_state == S_READY) && (w_state_nxt == S_COUNTING);
        w_preset_nxt        = r_preset;
        w_edit_digit_nxt    = r_edit_digit;
        w_counter_reset_nxt = (w_state_nxt == S_READY) || (w_state_nxt == S_SETTING) || w_load;
        w_alarm_nxt         = (w_state_nxt == S_ALARM);
        w_tick_cnt_nxt      = '0;
        w_mask_nxt          = (r_mask != '0) ? r_mask - MASK_W'(1) : '0;

        if (w_load)
            w_mask_nxt = MASK_W'(2);

        if ((r_state == S_ALARM) && (w_state_nxt == S_ALARM))
            w_tick_cnt_nxt = ctl.secTick ? r_tick_cnt + TICK_W'(1) : r_tick_cnt;

        if ((r_state == S_READY) && w_mode_p)
            w_edit_digit_nxt = 2'd3;

        if (r_state == S_SETTING) begin
            if (w_mode_p) begin
                w_edit_digit_nxt = (r_edit_digit == 2'd0) ? 2'd3 : r_edit_digit - 2'd1;
            end else if (w_up_p) begin
                case (r_edit_digit)
                    2'd3:    w_preset_nxt[15:12] = bcd_inc(r_preset[15:12], 4'd9);
                    2'd2:    w_preset_nxt[11:8]  = bcd_inc(r_preset[11:8],  4'd9);
                    2'd1:    w_preset_nxt[7:4]   = bcd_inc(r_preset[7:4],   4'd5);
                    default: w_preset_nxt[3:0]   = bcd_inc(r_preset[3:0],   4'd9);
                endcase
            end
        end
    end

    assign ctl.currentState      = r_state;
    assign ctl.initialClockValue = r_preset;
    assign ctl.counterReset      = r_counter_reset;
    assign ctl.editDigit         = r_edit_digit;
    assign ctl.alarm             = r_alarm;

endmodule

// File: tb/tb_countdown_mode_controller.sv
// Bench for the countdown sequencer: behavioural model compared every cycle plus literal pins.
module tb_countdown_mode_controller;

    localparam int ALARM_TICKS = 10;
    localparam int ST_COUNT = 0, ST_SET = 1, ST_READY = 2, ST_PAUSE = 3, ST_ALARM = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    countdown_mode_controller_if ifc();

    countdown_mode_controller #(
        .DEFAULT_TIME(16'h0500),
        .ALARM_TICKS (ALARM_TICKS)
    ) dut (
        .slowclk(clk),
        .reset  (rst_n),
        .ctl    (ifc.slave)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: digits as an array, phase as a plain number, mask as cycles since load.
    int m_state, m_edit, m_cr, m_alarm, m_ticks, m_age;
    int m_dig [4];
    bit m_pm, m_ps, m_pu;

    function automatic int m_preset();
        return m_dig[3] * 4096 + m_dig[2] * 256 + m_dig[1] * 16 + m_dig[0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = ST_READY; m_edit = 3; m_cr = 1; m_alarm = 0; m_ticks = 0; m_age = 2;
            m_dig[3] = 0; m_dig[2] = 5; m_dig[1] = 0; m_dig[0] = 0;
            m_pm = 0; m_ps = 0; m_pu = 0;
        end else begin
            bit pm, ps, pu, load;
            int ns, lim;
            pm = ifc.btnMode && !m_pm;
            ps = ifc.btnStart && !m_ps;
            pu = ifc.btnUp && !m_pu;
            m_pm = ifc.btnMode; m_ps = ifc.btnStart; m_pu = ifc.btnUp;
            ns = m_state;
            load = 0;
            case (m_state)
                ST_READY: begin
                    if (pm) begin ns = ST_SET; m_edit = 3; end
                    else if (ps && m_preset() != 0) begin ns = ST_COUNT; load = 1; end
                end
                ST_SET: begin
                    if (pm) begin
                        if (m_edit == 0) begin ns = ST_READY; m_edit = 3; end
                        else m_edit = m_edit - 1;
                    end else if (!ps && pu) begin
                        lim = (m_edit == 1) ? 5 : 9;
                        m_dig[m_edit] = (m_dig[m_edit] >= lim) ? 0 : m_dig[m_edit] + 1;
                    end
                end
                ST_COUNT: begin
                    if (pm) ns = ST_READY;
                    else if (ps) ns = ST_PAUSE;
                    else if (ifc.finished && m_age >= 2) ns = ST_ALARM;
                end
                ST_PAUSE: begin
                    if (pm) ns = ST_READY;
                    else if (ps) ns = ST_COUNT;
                end
                default: begin
                    if (pm || ps || pu) begin ns = ST_READY; m_ticks = 0; end
                    else if (ifc.secTick) begin
                        m_ticks = m_ticks + 1;
                        if (m_ticks == ALARM_TICKS) begin ns = ST_READY; m_ticks = 0; end
                    end
                end
            endcase
            if (load) m_age = 0;
            else if (m_age < 2) m_age = m_age + 1;
            m_cr = (ns == ST_READY || ns == ST_SET || load) ? 1 : 0;
            m_alarm = (ns == ST_ALARM) ? 1 : 0;
            m_state = ns;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("state", int'(ifc.currentState), m_state);
            chk("preset", int'(ifc.initialClockValue), m_preset());
            chk("counterReset", int'(ifc.counterReset), m_cr);
            chk("editDigit", int'(ifc.editDigit), m_edit);
            chk("alarm", int'(ifc.alarm), m_alarm);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic m, input logic s, input logic u);
        ifc.btnMode = m; ifc.btnStart = s; ifc.btnUp = u;
        tick();
        ifc.btnMode = 0; ifc.btnStart = 0; ifc.btnUp = 0;
        tick();
    endtask

    task automatic sec_pulse();
        ifc.secTick = 1;
        tick();
        ifc.secTick = 0;
        tick();
    endtask

    initial begin
        ifc.btnMode = 0; ifc.btnStart = 0; ifc.btnUp = 0;
        ifc.secTick = 0; ifc.finished = 0;
        #12;
        chk("rst_state", int'(ifc.currentState), 2);
        chk("rst_preset", int'(ifc.initialClockValue), 16'h0500);
        chk("rst_cr", int'(ifc.counterReset), 1);
        chk("rst_edit", int'(ifc.editDigit), 3);
        chk("rst_alarm", int'(ifc.alarm), 0);
        #10 rst_n = 1;
        tick();

        // Load strobe lasts exactly one cycle.
        ifc.btnStart = 1;
        tick();
        chk("load_state", int'(ifc.currentState), 0);
        chk("load_cr_hi", int'(ifc.counterReset), 1);
        ifc.btnStart = 0;
        tick();
        chk("load_cr_lo", int'(ifc.counterReset), 0);

        // Pause and resume without reload.
        press(0, 1, 0);
        chk("paused", int'(ifc.currentState), 3);
        repeat (5) tick();
        press(0, 1, 0);
        chk("resumed", int'(ifc.currentState), 0);
        chk("resume_no_load", int'(ifc.counterReset), 0);
        press(1, 0, 0);
        chk("abort", int'(ifc.currentState), 2);

        // Edit preset to 7000 via wraps.
        press(1, 0, 0);
        chk("setting", int'(ifc.currentState), 1);
        repeat (7) press(0, 0, 1);
        chk("min1_7", int'(ifc.initialClockValue), 16'h7500);
        press(1, 0, 0);
        repeat (5) press(0, 0, 1);
        press(1, 0, 0);
        chk("edit_sec1", int'(ifc.editDigit), 1);
        repeat (6) press(0, 0, 1);
        chk("preset_7000", int'(ifc.initialClockValue), 16'h7000);
        press(1, 0, 0);
        press(1, 0, 0);
        chk("back_ready", int'(ifc.currentState), 2);
        chk("edit_back_3", int'(ifc.editDigit), 3);

        // finished masked for load cycle and the one after.
        ifc.btnStart = 1;
        tick();
        ifc.btnStart = 0;
        ifc.finished = 1;
        tick();
        chk("mask0", int'(ifc.currentState), 0);
        tick();
        chk("mask1", int'(ifc.currentState), 0);
        tick();
        chk("alarm_entry", int'(ifc.currentState), 4);
        chk("alarm_hi", int'(ifc.alarm), 1);
        ifc.finished = 0;
        for (int i = 0; i < ALARM_TICKS; i++) begin
            sec_pulse();
            if (i == ALARM_TICKS - 2) chk("alarm_9th", int'(ifc.currentState), 4);
        end
        chk("alarm_exit", int'(ifc.currentState), 2);
        chk("alarm_lo", int'(ifc.alarm), 0);

        // Button cuts the alarm short.
        press(0, 1, 0);
        tick();
        ifc.finished = 1;
        tick();
        ifc.finished = 0;
        chk("alarm2", int'(ifc.currentState), 4);
        repeat (3) sec_pulse();
        ifc.btnUp = 1;
        tick();
        chk("alarm_abort", int'(ifc.currentState), 2);
        chk("alarm_abort_lo", int'(ifc.alarm), 0);
        ifc.btnUp = 0;
        tick();

        // Mode wins over start on the same edge.
        press(1, 1, 0);
        chk("prio_set", int'(ifc.currentState), 1);
        repeat (4) press(1, 0, 0);
        chk("prio_ready", int'(ifc.currentState), 2);

        // Held start yields one pause.
        press(0, 1, 0);
        ifc.btnStart = 1;
        repeat (20) tick();
        chk("hold_pause", int'(ifc.currentState), 3);
        ifc.btnStart = 0;
        tick();
        press(0, 1, 0);
        chk("hold_resume", int'(ifc.currentState), 0);

        // Zero preset refuses to start.
        press(1, 0, 0);
        press(1, 0, 0);
        repeat (3) press(0, 0, 1);
        chk("preset_zero", int'(ifc.initialClockValue), 0);
        repeat (4) press(1, 0, 0);
        press(0, 1, 0);
        chk("zero_stay", int'(ifc.currentState), 2);

        // Async reset in the middle of the alarm.
        press(1, 0, 0);
        press(0, 0, 1);
        repeat (4) press(1, 0, 0);
        chk("preset_1000", int'(ifc.initialClockValue), 16'h1000);
        press(0, 1, 0);
        tick();
        ifc.finished = 1;
        tick();
        ifc.finished = 0;
        repeat (2) sec_pulse();
        chk("pre_rst_alarm", int'(ifc.alarm), 1);
        #2 rst_n = 0;
        #1;
        chk("async_state", int'(ifc.currentState), 2);
        chk("async_alarm", int'(ifc.alarm), 0);
        chk("async_preset", int'(ifc.initialClockValue), 16'h0500);
        #10 rst_n = 1;
        tick();
        press(0, 1, 0);
        chk("post_rst_start", int'(ifc.currentState), 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
